// File: rtl/spi_tx.sv
// Serial word transmitter, MSB first, one bit per clk edge; pairs with spi_rx on the same clock.
// Define SPI_TX_BUF_EN to add a 1-entry holding buffer for gap-free back-to-back words.
module spi_tx #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] byte_in,
   input  logic             load,
   output logic             ready,
   input  logic             abort,
   output logic             bit_out,
   output logic             active,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             start_en;
   logic [WIDTH-1:0] start_word;
   logic             last_bit;

   assign last_bit = (state == SHIFT) && (cnt == '0);

`ifdef SPI_TX_BUF_EN
   logic [WIDTH-1:0] hold;
   logic             hold_valid;

   assign ready = !hold_valid;

   // A word starts from idle, or straight after the final bit so consecutive words have no gap.
   always_comb begin
      start_en   = 1'b0;
      start_word = byte_in;
      if (state == IDLE) begin
         start_en = load;
      end else if (last_bit) begin
         if (hold_valid) begin
            start_en   = 1'b1;
            start_word = hold;
         end else begin
            start_en = load;
         end
      end
   end
`else
   assign ready = (state == IDLE);

   always_comb begin
      start_en   = (state == IDLE) && load;
      start_word = byte_in;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         cnt     <= '0;
         bit_out <= 1'b0;
         active  <= 1'b0;
         done    <= 1'b0;
`ifdef SPI_TX_BUF_EN
         hold       <= '0;
         hold_valid <= 1'b0;
`endif
      end else if (abort) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_out <= 1'b0;
         active  <= 1'b0;
         done    <= 1'b0;
`ifdef SPI_TX_BUF_EN
         hold_valid <= 1'b0;
`endif
      end else begin
         done <= last_bit;
         if (start_en) begin
            bit_out <= start_word[WIDTH-1];
            shreg   <= start_word << 1;
            cnt     <= CW'(WIDTH - 1);
            active  <= 1'b1;
            state   <= SHIFT;
`ifdef SPI_TX_BUF_EN
            if (last_bit && hold_valid) hold_valid <= 1'b0;
`endif
         end else if (last_bit) begin
            bit_out <= 1'b0;
            active  <= 1'b0;
            state   <= IDLE;
         end else if (state == SHIFT) begin
            bit_out <= shreg[WIDTH-1];
            shreg   <= shreg << 1;
            cnt     <= cnt - 1'b1;
`ifdef SPI_TX_BUF_EN
            if (load && ready) begin
               hold       <= byte_in;
               hold_valid <= 1'b1;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_spi_tx.sv
// Self-checking bench for spi_tx: expected serial bits queued at load time, popped per active cycle.
// Handshake: a word is transferred on a rising edge where load && ready are both 1.
module tb_spi_tx;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] byte_in;
   logic         load;
   logic         ready;
   logic         abort;
   logic         bit_out;
   logic         active;
   logic         done;

   logic         exp_q[$];
   int           checks = 0;
   int           errors = 0;
   int           done_cnt = 0;
   bit           mon_en = 1'b0;

   spi_tx #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .byte_in (byte_in),
      .load    (load),
      .ready   (ready),
      .abort   (abort),
      .bit_out (bit_out),
      .active  (active),
      .done    (done)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // scoreboard: one expected bit consumed per active cycle, sampled mid-cycle
   always @(negedge clk) begin
      if (mon_en) begin
         if (done) done_cnt++;
         if (active) begin
            if (exp_q.size() == 0) check("stray_bit", active, 0);
            else check("bit_out", bit_out, exp_q.pop_front());
         end else begin
            check("idle_bit", bit_out, 0);
         end
      end
   end

   // driver tasks
   task automatic send(input logic [W-1:0] w);
      for (int i = 0; i < 40 && !ready; i++) tick();
      check("ready_wait", ready, 1);
      byte_in = w;
      load    = 1'b1;
      for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
      tick();
      load    = 1'b0;
      byte_in = $urandom_range(0, 255);
   endtask

   task automatic wait_done(input logic exp_active);
      for (int i = 0; i < 40 && !done; i++) tick();
      check("done_seen", done, 1);
      check("active_at_done", active, exp_active);
      if (!exp_active) check("ready_at_done", ready, 1);
   endtask

   int d0;

   initial begin
      rst = 1'b1; load = 1'b0; abort = 1'b0; byte_in = '0;
      repeat (2) tick();
      check("rst_bit_out", bit_out, 0);
      check("rst_active", active, 0);
      check("rst_done", done, 0);
      check("rst_ready", ready, 1);
      rst = 1'b0;
      mon_en = 1'b1;
      tick();

      // basic word 0xCA
      d0 = done_cnt;
      send(8'hCA);
      check("first_bit", bit_out, 1);
      wait_done(1'b0);
      tick();
      check("done_pulse_len", done, 0);
      check("cnt_ca", done_cnt - d0, 1);
      check("q_empty_ca", exp_q.size(), 0);

`ifndef SPI_TX_BUF_EN
      // load while busy is ignored
      d0 = done_cnt;
      send(8'hCA);
      repeat (2) tick();
      check("busy_ready", ready, 0);
      byte_in = 8'hFF; load = 1'b1;
      tick();
      load = 1'b0;
      wait_done(1'b0);
      tick();
      check("cnt_ignored_load", done_cnt - d0, 1);
      check("q_empty_ign", exp_q.size(), 0);
`endif

      // abort mid-word, with a simultaneous load that must be ignored
      d0 = done_cnt;
      send(8'h3F);
      repeat (2) tick();
      abort = 1'b1; load = 1'b1; byte_in = 8'h55;
      tick();
      abort = 1'b0; load = 1'b0;
      exp_q.delete();
      check("abort_bit_out", bit_out, 0);
      check("abort_active", active, 0);
      check("abort_ready", ready, 1);
      repeat (12) tick();
      check("abort_no_done", done_cnt - d0, 0);
      send(8'hA7);
      wait_done(1'b0);
      tick();
      check("cnt_after_abort", done_cnt - d0, 1);

      // abort while idle
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("idle_abort_ready", ready, 1);
      check("idle_abort_active", active, 0);

      // reset mid-word
      d0 = done_cnt;
      send(8'h96);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      check("mid_rst_bit_out", bit_out, 0);
      check("mid_rst_active", active, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_ready", ready, 1);
      repeat (12) tick();
      check("mid_rst_no_done", done_cnt - d0, 0);

      // random words, sent back to back as fast as ready allows
      d0 = done_cnt;
      for (int n = 0; n < 6; n++) begin
         send(W'($urandom_range(0, 255)));
         wait_done(1'b0);
         tick();
      end
      check("cnt_random", done_cnt - d0, 6);

`ifdef SPI_TX_BUF_EN
      // buffered pair: zero-gap stream 00111111 10100111
      d0 = done_cnt;
      send(8'h3F);
      tick();
      send(8'hA7);
      check("buf_full_ready", ready, 0);
      wait_done(1'b1);
      tick();
      wait_done(1'b0);
      tick();
      check("cnt_buf", done_cnt - d0, 2);
`endif

      repeat (3) tick();
      check("q_empty_final", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
